rgbw_frame_tx: RTL and testbench



---
 rtl/rgbw_frame_tx.sv | 152 +++++++++++++++
 tb/tb_rgbw_frame_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgbw_frame_tx.sv
// rtl/rgbw_frame_tx.sv - SPI mode-0 master sending one 8-byte RGBW control frame
// Frame: SYNC_BYTE, lint, colorIdx, red, green, blue, white, mode; MSB first.
module rgbw_frame_tx #(
   parameter int         CLK_DIV   = 2,
   parameter int         BYTE_GAP  = 1,
   parameter logic [7:0] SYNC_BYTE = 8'h55
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] lint_in,
   input  logic [7:0] colorIdx_in,
   input  logic [7:0] red_in,
   input  logic [7:0] green_in,
   input  logic [7:0] blue_in,
   input  logic [7:0] white_in,
   input  logic [7:0] mode_in,
   output logic       sclk,
   output logic       mosi,
   output logic       cs_n,
   output logic       busy,
   output logic       done
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] GAP   = 3'd3;
   localparam logic [2:0] HOLD  = 3'd4;

   logic [2:0]       state;
   logic [DIV_W-1:0] div_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [2:0]       byte_idx;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_prev;
   logic [2:0]       byte_next;
   logic [7:0]       frame_buf [8];
   logic             tick;
   logic             accept;

   assign tick   = (div_cnt == DIV_LAST);
   assign accept = (state == IDLE) && start;

   always_comb begin
      bit_prev  = bit_idx - 3'd1;
      byte_next = byte_idx + 3'd1;
   end

   // Snapshot so that input changes during a frame never reach the wire.
   always_ff @(posedge clk) begin
      if (accept && !reset) begin
         frame_buf[0] <= SYNC_BYTE;
         frame_buf[1] <= lint_in;
         frame_buf[2] <= colorIdx_in;
         frame_buf[3] <= red_in;
         frame_buf[4] <= green_in;
         frame_buf[5] <= blue_in;
         frame_buf[6] <= white_in;
         frame_buf[7] <= mode_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         div_cnt  <= '0;
         gap_cnt  <= '0;
         byte_idx <= '0;
         bit_idx  <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         // Wrapping on every tick also clears the divider on each state entry.
         if (state != IDLE) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               div_cnt <= '0;
               if (start) begin
                  state    <= SETUP;
                  cs_n     <= 1'b0;
                  busy     <= 1'b1;
                  mosi     <= SYNC_BYTE[7];
                  byte_idx <= 3'd0;
                  bit_idx  <= 3'd7;
                  gap_cnt  <= '0;
               end
            end
            SETUP: begin
               if (tick) state <= SHIFT;
            end
            SHIFT: begin
               if (tick) begin
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else begin
                     sclk <= 1'b0;
                     if (bit_idx != 3'd0) begin
                        bit_idx <= bit_prev;
                        mosi    <= frame_buf[byte_idx][bit_prev];
                     end else if (byte_idx == 3'd7) begin
                        state <= HOLD;
                     end else begin
                        byte_idx <= byte_next;
                        bit_idx  <= 3'd7;
                        mosi     <= frame_buf[byte_next][7];
                        if (BYTE_GAP != 0) begin
                           state   <= GAP;
                           gap_cnt <= '0;
                        end
                     end
                  end
               end
            end
            GAP: begin
               if (tick) begin
                  if (gap_cnt == GAP_LAST) state <= SHIFT;
                  else gap_cnt <= gap_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (tick) begin
                  state <= IDLE;
                  cs_n  <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  mosi  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               sclk  <= 1'b0;
               mosi  <= 1'b0;
               cs_n  <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rgbw_frame_tx.sv
// tb/tb_rgbw_frame_tx.sv - scoreboard bench for rgbw_frame_tx
// Instance a uses default parameters, instance b uses CLK_DIV=1, BYTE_GAP=0.
module tb_rgbw_frame_tx;

   localparam int DIV_A = 2;
   localparam int DIV_B = 1;
   localparam logic [63:0] FRAME_DEF = 64'h55FF_0312_3456_7801;
   localparam logic [63:0] FRAME_AA  = 64'h55AA_AAAA_AAAA_AAAA;

   typedef struct {
      logic [63:0] bytes;
      int          low_len;
      bit          aborted;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic [7:0] lint, color, red, green, blue, white, mode;
   logic sclk_a, mosi_a, cs_n_a, busy_a, done_a;
   logic sclk_b, mosi_b, cs_n_b, busy_b, done_b;
   logic [1:0] sclk_v, mosi_v, cs_n_v, done_v;

   int errors = 0;
   int checks = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   int low_len[2];
   int rises[2];
   int viol[2];
   int stable[2];
   logic [63:0] shift[2];
   logic [1:0] prev_csn  = 2'b11;
   logic [1:0] prev_sclk = 2'b00;
   logic [1:0] prev_mosi = 2'b00;
   int stray_done = 0;
   int idle_viol  = 0;

   always #5 clk = ~clk;

   rgbw_frame_tx dut_a (
      .clk(clk), .reset(reset), .start(start_a),
      .lint_in(lint), .colorIdx_in(color), .red_in(red), .green_in(green),
      .blue_in(blue), .white_in(white), .mode_in(mode),
      .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .busy(busy_a), .done(done_a)
   );

   rgbw_frame_tx #(.CLK_DIV(DIV_B), .BYTE_GAP(0), .SYNC_BYTE(8'h55)) dut_b (
      .clk(clk), .reset(reset), .start(start_b),
      .lint_in(lint), .colorIdx_in(color), .red_in(red), .green_in(green),
      .blue_in(blue), .white_in(white), .mode_in(mode),
      .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .busy(busy_b), .done(done_b)
   );

   assign sclk_v = {sclk_b, sclk_a};
   assign mosi_v = {mosi_b, mosi_a};
   assign cs_n_v = {cs_n_b, cs_n_a};
   assign done_v = {done_b, done_a};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic frame_end(input int k);
      exp_t e;
      bit have;
      string sfx;
      sfx = (k == 0) ? "a" : "b";
      have = 1'b0;
      if (k == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      if (k == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      if (!have) begin
         check({"unexpected_frame_", sfx}, 64'd1, 64'd0);
      end else if (e.aborted) begin
         check({"abort_no_done_", sfx}, {63'd0, done_v[k]}, 64'd0);
         check({"abort_partial_", sfx}, {63'd0, (rises[k] < 64)}, 64'd1);
      end else begin
         check({"frame_bytes_", sfx}, shift[k], e.bytes);
         check({"cs_low_len_", sfx}, 64'(low_len[k]), 64'(e.low_len));
         check({"sclk_rises_", sfx}, 64'(rises[k]), 64'd64);
         check({"done_at_end_", sfx}, {63'd0, done_v[k]}, 64'd1);
         check({"mosi_stable_", sfx}, 64'(viol[k]), 64'd0);
      end
   endtask

   // SPI slave model: samples on falling clk, decodes on rising sclk.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            if (mosi_v[k] !== prev_mosi[k]) begin
               if (sclk_v[k] === 1'b1) viol[k]++;
               stable[k] = 0;
            end else begin
               stable[k]++;
            end
            if (cs_n_v[k] === 1'b0) begin
               if (prev_csn[k] === 1'b1) begin
                  low_len[k] = 0;
                  rises[k]   = 0;
                  shift[k]   = '0;
                  viol[k]    = 0;
               end
               low_len[k]++;
               if (sclk_v[k] === 1'b1 && prev_sclk[k] === 1'b0) begin
                  rises[k]++;
                  shift[k] = {shift[k][62:0], mosi_v[k]};
                  if (stable[k] < ((k == 0) ? DIV_A : DIV_B)) viol[k]++;
               end
            end else begin
               if (sclk_v[k] !== 1'b0) idle_viol++;
               if (prev_csn[k] === 1'b0) frame_end(k);
            end
            if (done_v[k] === 1'b1 && !(cs_n_v[k] === 1'b1 && prev_csn[k] === 1'b0))
               stray_done++;
         end
         prev_csn[k]  = cs_n_v[k];
         prev_sclk[k] = sclk_v[k];
         prev_mosi[k] = mosi_v[k];
      end
   end

   task automatic set_inputs(input logic [7:0] v0, v1, v2, v3, v4, v5, v6);
      lint = v0; color = v1; red = v2; green = v3; blue = v4; white = v5; mode = v6;
   endtask

   task automatic pulse_start(input int k);
      @(posedge clk); #1;
      if (k == 0) start_a = 1'b1; else start_b = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic push_exp(input int k, input logic [63:0] bytes, input int len, input bit ab);
      exp_t e;
      e.bytes = bytes; e.low_len = len; e.aborted = ab;
      if (k == 0) q_a.push_back(e); else q_b.push_back(e);
   endtask

   task automatic wait_done(input int k, input int max_cyc, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done_v[k] !== 1'b1 && n < max_cyc);
      check(name, {63'd0, done_v[k]}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      set_inputs(8'hFF, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cs_n_a", {63'd0, cs_n_a}, 64'd1);
      check("rst_sclk_a", {63'd0, sclk_a}, 64'd0);
      check("rst_mosi_a", {63'd0, mosi_a}, 64'd0);
      check("rst_busy_a", {63'd0, busy_a}, 64'd0);
      check("rst_done_a", {63'd0, done_a}, 64'd0);
      check("rst_cs_n_b", {63'd0, cs_n_b}, 64'd1);
      check("rst_busy_b", {63'd0, busy_b}, 64'd0);
      @(posedge clk); #1 reset = 1'b0;

      // Default frame on both parameterisations.
      push_exp(0, FRAME_DEF, 274, 1'b0);
      pulse_start(0);
      wait_done(0, 400, "done_def_a");
      push_exp(1, FRAME_DEF, 130, 1'b0);
      pulse_start(1);
      wait_done(1, 200, "done_def_b");

      // Inputs change and start is held mid-frame; restart follows done by one cycle.
      push_exp(0, FRAME_DEF, 274, 1'b0);
      push_exp(0, FRAME_AA, 274, 1'b0);
      pulse_start(0);
      repeat (115) @(posedge clk);
      #1;
      set_inputs(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
      start_a = 1'b1;
      wait_done(0, 300, "done_hold_a");
      @(negedge clk);
      check("restart_cs_n", {63'd0, cs_n_a}, 64'd0);
      check("restart_busy", {63'd0, busy_a}, 64'd1);
      @(posedge clk); #1 start_a = 1'b0;
      set_inputs(8'hFF, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01);
      wait_done(0, 400, "done_aa_a");
      repeat (5) @(negedge clk);
      check("no_queue_cs_n", {63'd0, cs_n_a}, 64'd1);

      // Reset during the white byte abandons the frame.
      push_exp(0, FRAME_DEF, 274, 1'b1);
      pulse_start(0);
      repeat (210) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("abort_cs_n", {63'd0, cs_n_a}, 64'd1);
      check("abort_sclk", {63'd0, sclk_a}, 64'd0);
      check("abort_mosi", {63'd0, mosi_a}, 64'd0);
      check("abort_busy", {63'd0, busy_a}, 64'd0);
      check("abort_done", {63'd0, done_a}, 64'd0);
      repeat (4) @(posedge clk);
      push_exp(0, FRAME_DEF, 274, 1'b0);
      pulse_start(0);
      wait_done(0, 400, "done_after_abort");

      // Reset and start together from IDLE.
      @(posedge clk); #1;
      reset = 1'b1;
      start_a = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      start_a = 1'b0;
      @(negedge clk);
      check("rst_start_cs_n", {63'd0, cs_n_a}, 64'd1);
      check("rst_start_busy", {63'd0, busy_a}, 64'd0);
      repeat (5) @(negedge clk);
      check("rst_start_idle", {63'd0, cs_n_a}, 64'd1);

      check("queue_a_empty", 64'(q_a.size()), 64'd0);
      check("queue_b_empty", 64'(q_b.size()), 64'd0);
      check("stray_done", 64'(stray_done), 64'd0);
      check("sclk_idle_low", 64'(idle_viol), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
